top_without_bc: RTL and testbench
=================================

# top_without_bc

N-bit registered adder/subtractor core used as the DFT example design before boundary-scan cells are inserted. It adds or subtracts two N-bit operands with carry-in under a mode select, and presents sum and carry-out through a two-stage register pipeline. It sits directly under the chip-level pin ring. All I/O uses the `pin_` prefix, and the boundary-cell wrapper attaches to these ports later.

## Interface
Parameters:
- N, 16, operand/sum width; must be a multiple of 4 and at least 4.

Ports:
- One clock; reset is synchronous and active-high.
- pin_clk  input  1  single clock; all state updates on rising edge.
- pin_rst  input  1  synchronous active-high reset.
- pin_a  input  N  operand A.
- pin_b  input  N  operand B.
- pin_cin  input  1  carry-in (add) / borrow-in (subtract).
- pin_sel  input  1  mode: 0 = add, 1 = subtract.
- pin_sum  output  N  registered result, low N bits.
- pin_co  output  1  registered carry-out; in subtract mode 1 = no borrow.

## Operation
- Stage 1: registers a_q, b_q, cin_q, sel_q capture pin_a, pin_b, pin_cin, pin_sel every cycle.
- Combinational core between the stages:
  - bx = b_q XOR {N{sel_q}}.
  - c0 = cin_q XOR sel_q.
  - {co, sum} = a_q + bx + c0, computed at N+1 bits.
- Resulting modes:
  - sel=0: {co, sum} = A + B + cin.
  - sel=1, cin=0: sum = A − B (mod 2^N).
  - sel=1, cin=1: sum = A − B − 1.
  - co is the raw adder carry.
- Adder structure:
  - N/4 four-bit carry-lookahead groups, each using generate/propagate per bit.
  - Group carries ripple between groups.
  - Group carry-out = G + P·cin.
  - Purely combinational; no latches.
- Stage 2: pin_sum and pin_co are registered from sum and co.
- Width rules:
  - Wrap-around is modulo 2^N; overflow is not flagged in the base build.
  - Inputs are treated as unsigned.
- Reset: when pin_rst=1 at a rising edge, all stage-1 and stage-2 registers load 0. Reset takes priority over capture.

## Timing
- Latency is 2 cycles.
  - Inputs sampled at edge k appear on pin_sum/pin_co after edge k+1.
  - Throughput is one operation per cycle; there is no handshake and no stall.
- Reset values: pin_sum = 0, pin_co = 0 (held while pin_rst is high).
- First valid output after reset release: inputs sampled at the first edge with pin_rst=0 appear after the following edge.
- Reset asserted mid-pipeline:
  - In-flight results are discarded.
  - Outputs are 0 after the asserting edge.
  - Stage 1 is also zeroed, so the next output is 0+0+0 = 0.
- Inputs must meet setup/hold to pin_clk; asynchronous input changes between edges have no effect.

## Configuration
- Macro: TOP_WITHOUT_BC_OVF_EN.
- Defined:
  - Adds output port pin_ovf (output, 1 bit) after pin_co.
  - pin_ovf is the registered two's-complement overflow: carry into bit N-1 XOR carry out of bit N-1.
  - Same 2-cycle latency as pin_sum; resets to 0.
- Undefined: port pin_ovf and its register are absent; all other behaviour is identical.

## Test plan
- Reset: hold pin_rst=1 for 2 cycles with A=FFFF, B=FFFF -> pin_sum=0000, pin_co=0 throughout.
- Add, no carry: A=0000, B=FFFF, cin=0, sel=0 -> after 2 cycles pin_sum=FFFF, pin_co=0.
- Add, carry chain: A=FFFF, B=0000, cin=1, sel=0 -> pin_sum=0000, pin_co=1. This exercises the full group ripple.
- Subtract: A=000F, B=0000, cin=0, sel=1 -> pin_sum=000F, pin_co=1. Then A=0000, B=0001, sel=1 -> pin_sum=FFFF, pin_co=0 (borrow).
- Pipeline: back-to-back vectors on consecutive cycles, (1+2), (3−1), (8000+8000) -> outputs 0003/0, 0002/1, 0000/1 on three consecutive cycles. With TOP_WITHOUT_BC_OVF_EN, pin_ovf=1 only on the third.
- Mid-operation reset: pin_rst pulsed for 1 cycle between the two operations above -> outputs 0 on the following cycle, and no stale result appears afterwards.

Source files
------------

// File: rtl/top_without_bc.sv
// ---------------------------------------------------------------------------
// top_without_bc
//   N-bit registered adder/subtractor core. Operands are registered (stage 1),
//   summed by a ripple of 4-bit carry-lookahead groups, and the result is
//   registered again (stage 2). Latency 2 cycles, one operation per cycle.
//
//   Optional feature macro: TOP_WITHOUT_BC_OVF_EN
//     When defined, adds pin_ovf, the registered two's-complement overflow.
//
// Ports
//   pin_clk   in   1  clock, rising edge
//   pin_rst   in   1  synchronous active-high reset (zeroes both stages)
//   pin_a     in   N  operand A
//   pin_b     in   N  operand B
//   pin_cin   in   1  carry-in (add) / borrow-in (subtract)
//   pin_sel   in   1  0 = add, 1 = subtract
//   pin_sum   out  N  registered result
//   pin_co    out  1  registered carry-out (subtract: 1 = no borrow)
//   pin_ovf   out  1  registered signed overflow (TOP_WITHOUT_BC_OVF_EN only)
//
// Parameter N must be a multiple of 4 and at least 4.
// ---------------------------------------------------------------------------

// One 4-bit carry-lookahead group. Internal bit carries are fully looked
// ahead; the group carry-out is G + P*cin so groups can ripple.
module top_without_bc_cla4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_s,
  output logic       o_c
);
  logic [3:0] w_g, w_p, w_c;
  logic       w_gg, w_gp;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_c;
  assign w_c[1] = w_g[0] | (w_p[0] & i_c);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_c);

  assign w_gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign w_gp = &w_p;

  assign o_c = w_gg | (w_gp & i_c);
  assign o_s = w_p ^ w_c;
endmodule

module top_without_bc #(
  parameter int N = 16
) (
  input  logic         pin_clk,
  input  logic         pin_rst,
  input  logic [N-1:0] pin_a,
  input  logic [N-1:0] pin_b,
  input  logic         pin_cin,
  input  logic         pin_sel,
  output logic [N-1:0] pin_sum,
  output logic         pin_co
`ifdef TOP_WITHOUT_BC_OVF_EN
  ,
  output logic         pin_ovf
`endif
);
  localparam int NG = N / 4;

  // Stage 1
  logic [N-1:0] r_a, r_b;
  logic         r_cin, r_sel;

  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cin <= 1'b0;
      r_sel <= 1'b0;
    end else begin
      r_a   <= pin_a;
      r_b   <= pin_b;
      r_cin <= pin_cin;
      r_sel <= pin_sel;
    end
  end

  // Subtract is A + ~B + ~cin: invert B and the carry-in under sel.
  logic [N-1:0] w_bx;
  logic [N-1:0] w_sum;
  logic [NG:0]  w_gc;

  assign w_bx    = r_b ^ {N{r_sel}};
  assign w_gc[0] = r_cin ^ r_sel;

  for (genvar g = 0; g < NG; g++) begin : g_grp
    top_without_bc_cla4 u_cla (
      .i_a (r_a [4*g +: 4]),
      .i_b (w_bx[4*g +: 4]),
      .i_c (w_gc[g]),
      .o_s (w_sum[4*g +: 4]),
      .o_c (w_gc[g+1])
    );
  end

  // Stage 2
  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      pin_sum <= '0;
      pin_co  <= 1'b0;
    end else begin
      pin_sum <= w_sum;
      pin_co  <= w_gc[NG];
    end
  end

`ifdef TOP_WITHOUT_BC_OVF_EN
  // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
  logic w_cmsb, w_ovf;
  assign w_cmsb = w_sum[N-1] ^ r_a[N-1] ^ w_bx[N-1];
  assign w_ovf  = w_cmsb ^ w_gc[NG];

  always_ff @(posedge pin_clk) begin
    if (pin_rst) pin_ovf <= 1'b0;
    else         pin_ovf <= w_ovf;
  end
`endif
endmodule

// File: tb/tb_top_without_bc.sv
module tb_top_without_bc;
  localparam int N = 16;

  logic         pin_clk = 1'b0;
  logic         pin_rst = 1'b1;
  logic [N-1:0] pin_a   = '0;
  logic [N-1:0] pin_b   = '0;
  logic         pin_cin = 1'b0;
  logic         pin_sel = 1'b0;
  logic [N-1:0] pin_sum;
  logic         pin_co;
`ifdef TOP_WITHOUT_BC_OVF_EN
  logic         pin_ovf;
`endif

  top_without_bc #(.N(N)) dut (
    .pin_clk (pin_clk),
    .pin_rst (pin_rst),
    .pin_a   (pin_a),
    .pin_b   (pin_b),
    .pin_cin (pin_cin),
    .pin_sel (pin_sel),
    .pin_sum (pin_sum),
    .pin_co  (pin_co)
`ifdef TOP_WITHOUT_BC_OVF_EN
    ,
    .pin_ovf (pin_ovf)
`endif
  );

  always #5 pin_clk = ~pin_clk;

  // Expected stage-2 contents: {ovf, co, sum}
  typedef struct packed {
    logic         ovf;
    logic         co;
    logic [N-1:0] sum;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference: add = A+B+cin, sub = A-B-cin; co = no borrow in subtract.
  function automatic exp_t model(logic [N-1:0] a, logic [N-1:0] b,
                                 logic cin, logic sel);
    exp_t        e;
    logic [N:0]  r;
    logic [N-1:0] bo;
    if (!sel) begin
      r  = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
      bo = b;
    end else begin
      r  = {1'b1, a} - {1'b0, b} - {{N{1'b0}}, cin};
      bo = ~b;
    end
    e.sum = r[N-1:0];
    e.co  = r[N];
    e.ovf = (a[N-1] == bo[N-1]) && (e.sum[N-1] != a[N-1]);
    return e;
  endfunction

  // One clock: drive inputs, take the edge, then compare what stage 2 loaded.
  task automatic cyc(input string tag, input logic [N-1:0] a,
                     input logic [N-1:0] b, input logic cin,
                     input logic sel, input logic rst);
    exp_t e;
    logic ok_q;
    pin_a = a; pin_b = b; pin_cin = cin; pin_sel = sel; pin_rst = rst;
    @(posedge pin_clk);
    #1;
    ok_q = 1'b1;
    if (rst) begin
      e = '0;
      sb.delete();
      sb.push_back('0);
    end else if (sb.size() == 0) begin
      ok_q = 1'b0;
      e    = '0;
      sb.push_back(model(a, b, cin, sel));
    end else begin
      e = sb.pop_front();
      sb.push_back(model(a, b, cin, sel));
    end
    n_chk++;
    assert (ok_q) else begin
      n_fail++;
      $error("FAIL %s scoreboard empty got=0 need=1", tag);
    end
    n_chk++;
    assert (pin_sum === e.sum) else begin
      n_fail++;
      $error("FAIL %s sum got=%h need=%h", tag, pin_sum, e.sum);
    end
    n_chk++;
    assert (pin_co === e.co) else begin
      n_fail++;
      $error("FAIL %s co got=%b need=%b", tag, pin_co, e.co);
    end
`ifdef TOP_WITHOUT_BC_OVF_EN
    n_chk++;
    assert (pin_ovf === e.ovf) else begin
      n_fail++;
      $error("FAIL %s ovf got=%b need=%b", tag, pin_ovf, e.ovf);
    end
`endif
  endtask

  initial begin
    // Reset held two cycles with all-ones operands
    cyc("rst0", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    cyc("rst1", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);

    // Directed operations, back-to-back
    cyc("add_nc",  16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    cyc("add_cc",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc("sub_nb",  16'h000F, 16'h0000, 1'b0, 1'b1, 1'b0);
    cyc("sub_bw",  16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0);
    cyc("sub_cin", 16'h0005, 16'h0003, 1'b1, 1'b1, 1'b0);

    // Pipeline: 1+2, 3-1, 8000+8000
    cyc("pipe0", 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
    cyc("pipe1", 16'h0003, 16'h0001, 1'b0, 1'b1, 1'b0);
    cyc("pipe2", 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
    cyc("pipe3", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    cyc("pipe4", 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);

    // Reset pulsed between two operations: in-flight 1+2 must vanish
    cyc("mid0", 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
    cyc("midr", 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);
    cyc("mid1", 16'h0003, 16'h0001, 1'b0, 1'b1, 1'b0);
    cyc("mid2", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    cyc("mid3", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Random mix of both modes
    for (int i = 0; i < 40; i++)
      cyc("rnd", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);

    // Drain
    cyc("drain0", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    cyc("drain1", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
